// File: rtl/riscv_if_fetch_queue.sv
// Instruction fetch stage: ICACHE prefetch queue, RVC/32-bit realignment
// and IF/ID pipeline registers, with redirect handling during misses.
module riscv_if_fetch_queue #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     icache_stall,
    output logic                     icache_ren,
    output logic [PC_W-3:0]          icache_addr,
    input  logic [31:0]              icache_rdata,
    output logic [31:0]              inst_ppl,
    output logic [PC_W-1:0]          pc_ppl,
    output logic                     compressed_ppl,
    output logic                     valid_ppl,
    output logic [PC_W-1:0]          pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = PC_W - 2;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            hoff;
    logic [FW-1:0]   fwa;
    logic [FW-1:0]   drain_addr;
    logic            req_pend;

    logic            accept;
    logic            push;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic [15:0]     half;
    logic            is_rvc;
    logic            ready;
    logic            adv;
    logic            pop;
    logic [31:0]     inst;
    logic            unused_pc0;

    assign unused_pc0 = redirect_pc[0];

    // Request is held while a stalled access is outstanding.
    always_comb begin
        icache_ren = 1'b0;
        if (rst) begin
            icache_ren = 1'b0;
        end else if (state == DRAIN) begin
            icache_ren = 1'b1;
        end else begin
            icache_ren = req_pend ||
                ((queue_count < CW'(DEPTH)) && !redirect_valid);
        end
    end

    assign icache_addr = (state == DRAIN) ? drain_addr : fwa;
    assign accept      = icache_ren && !icache_stall;
    assign push        = accept && (state == RUN) && !redirect_valid;

    assign w0     = mem[rd_ptr];
    assign w1     = mem[rd_ptr + AW'(1)];
    assign half   = hoff ? w0[31:16] : w0[15:0];
    assign is_rvc = (half[1:0] != 2'b11);

    // Realign the head instruction and decide whether it is complete.
    always_comb begin
        inst  = w0;
        ready = 1'b0;
        if (is_rvc) begin
            inst  = {16'h0000, half};
            ready = (queue_count != '0);
        end else if (hoff) begin
            inst  = {w1[15:0], w0[31:16]};
            ready = (queue_count >= CW'(2));
        end else begin
            inst  = w0;
            ready = (queue_count != '0);
        end
    end

    assign adv = ready && !stall && !redirect_valid;
    assign pop = adv && (hoff || !is_rvc);

    // Queue storage; contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= icache_rdata;
        end
    end

    // Queue pointers, occupancy, fetch pointer and decode PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
            hoff        <= RESET_PC[1];
            pc          <= {RESET_PC[PC_W-1:1], 1'b0};
            fwa         <= RESET_PC[PC_W-1:2];
            req_pend    <= 1'b0;
        end else begin
            req_pend <= icache_ren && icache_stall;
            if (redirect_valid) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                queue_count <= '0;
                hoff        <= redirect_pc[1];
                pc          <= {redirect_pc[PC_W-1:1], 1'b0};
                fwa         <= redirect_pc[PC_W-1:2];
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    fwa    <= fwa + FW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                queue_count <= queue_count + CW'(push) - CW'(pop);
                if (adv) begin
                    pc   <= pc + (is_rvc ? PC_W'(2) : PC_W'(4));
                    hoff <= is_rvc ? ~hoff : hoff;
                end
            end
        end
    end

    // Fetch FSM: a redirected stalled request is drained and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            drain_addr <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect_valid && icache_ren && icache_stall) begin
                        state      <= DRAIN;
                        drain_addr <= fwa;
                    end
                end
                DRAIN: begin
                    if (!icache_stall) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // IF/ID registers: hold on stall, bubble when nothing can issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_ppl       <= NOP;
            pc_ppl         <= '0;
            compressed_ppl <= 1'b0;
            valid_ppl      <= 1'b0;
        end else if (!stall) begin
            if (flush || !ready || redirect_valid) begin
                inst_ppl       <= NOP;
                pc_ppl         <= pc;
                compressed_ppl <= 1'b0;
                valid_ppl      <= 1'b0;
            end else begin
                inst_ppl       <= inst;
                pc_ppl         <= pc;
                compressed_ppl <= is_rvc;
                valid_ppl      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_if_fetch_queue.sv
// Testbench for riscv_if_fetch_queue: directed scenarios plus randomized
// traffic checked every cycle against a halfword-level reference model.
module tb_riscv_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_stall;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic [31:0] inst_ppl;
    logic [31:0] pc_ppl;
    logic        compressed_ppl;
    logic        valid_ppl;
    logic [31:0] pc;
    logic [2:0]  queue_count;

    logic [31:0] prog [256];

    int errors = 0;
    int checks = 0;

    // model state
    int          m_cnt;
    logic [31:0] m_pc;
    logic [29:0] m_fwa;
    logic [29:0] m_daddr;
    bit          m_drain;
    bit          m_pend;
    logic [31:0] m_inst;
    logic [31:0] m_pcppl;
    bit          m_c;
    bit          m_v;

    riscv_if_fetch_queue #(
        .PC_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_stall(icache_stall), .icache_ren(icache_ren),
        .icache_addr(icache_addr), .icache_rdata(icache_rdata),
        .inst_ppl(inst_ppl), .pc_ppl(pc_ppl),
        .compressed_ppl(compressed_ppl), .valid_ppl(valid_ppl),
        .pc(pc), .queue_count(queue_count)
    );

    assign icache_rdata = prog[icache_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] half_at(logic [31:0] a);
        logic [31:0] w;
        w = prog[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit exp_ren();
        return m_drain || m_pend || (m_cnt < DEPTH && !redirect_valid);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pc = 0; m_fwa = 0; m_daddr = 0;
        m_drain = 0; m_pend = 0;
        m_inst = NOP; m_pcppl = 0; m_c = 0; m_v = 0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_next();
        logic [15:0] h;
        logic [31:0] ins;
        logic [29:0] old_fwa;
        bit rvc, rdy, adv, ren, acc;
        int size, need, popn, off;
        h    = half_at(m_pc);
        rvc  = (h[1:0] != 2'b11);
        size = rvc ? 2 : 4;
        off  = int'(m_pc[1:0]);
        need = (off + size + 3) / 4;
        popn = (off + size) / 4;
        rdy  = (m_cnt >= need);
        ins  = rvc ? {16'h0, h} : {half_at(m_pc + 2), h};
        ren  = exp_ren();
        acc  = ren && !icache_stall;
        adv  = rdy && !stall && !redirect_valid;
        old_fwa = m_fwa;
        if (!stall) begin
            m_pcppl = m_pc;
            if (flush || !rdy || redirect_valid) begin
                m_inst = NOP; m_c = 0; m_v = 0;
            end else begin
                m_inst = ins; m_c = rvc; m_v = 1;
            end
        end
        if (redirect_valid) begin
            m_cnt = 0;
            m_pc  = {redirect_pc[31:1], 1'b0};
            m_fwa = redirect_pc[31:2];
        end else begin
            if (acc && !m_drain) begin
                m_cnt++;
                m_fwa = m_fwa + 30'd1;
            end
            if (adv) begin
                m_cnt -= popn;
                m_pc = m_pc + 32'(size);
            end
        end
        if (!m_drain) begin
            if (redirect_valid && ren && icache_stall) begin
                m_drain = 1;
                m_daddr = old_fwa;
            end
        end else if (!icache_stall) begin
            m_drain = 0;
        end
        m_pend = ren && icache_stall;
    endtask

    // One cycle: compare every output against the model, then clock.
    task automatic step();
        #1;
        chk("icache_ren", icache_ren, exp_ren());
        chk("icache_addr", icache_addr, m_drain ? m_daddr : m_fwa);
        chk("inst_ppl", inst_ppl, m_inst);
        chk("pc_ppl", pc_ppl, m_pcppl);
        chk("compressed_ppl", compressed_ppl, m_c);
        chk("valid_ppl", valid_ppl, m_v);
        chk("pc", pc, m_pc);
        chk("queue_count", queue_count, m_cnt);
        model_next();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; flush = 0; redirect_valid = 0;
        redirect_pc = 0; icache_stall = 0;
        @(negedge clk);
        chk("rst_ren", icache_ren, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_inst", inst_ppl, NOP);
        chk("rst_valid", valid_ppl, 0);
        chk("rst_pc_ppl", pc_ppl, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (valid_ppl !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_wait_valid"}, valid_ppl, 1'b1);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) prog[i] = NOP;
    endtask

    task automatic expect_out(string name, logic [31:0] i,
                              logic [31:0] p, bit c);
        chk({name, "_inst"}, inst_ppl, i);
        chk({name, "_pc"}, pc_ppl, p);
        chk({name, "_c"}, compressed_ppl, c);
        chk({name, "_valid"}, valid_ppl, 1'b1);
    endtask

    // Bring the fetch unit into DRAIN with word 5 outstanding.
    task automatic enter_drain();
        int n = 0;
        while (icache_addr !== 30'd5 && n < 40) begin
            step();
            n++;
        end
        chk("miss_addr5", icache_addr, 5);
        icache_stall = 1;
        step();
        redirect_valid = 1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 0;
        redirect_pc = 0;
    endtask

    initial begin
        rst = 1;
        fill_nop();
        model_reset();

        // sequential 32-bit fetch
        prog[0] = 32'h00000013;
        prog[1] = 32'h00100093;
        prog[2] = 32'h00200113;
        do_reset();
        chk("seq_addr0", icache_addr, 0);
        chk("seq_ren0", icache_ren, 1);
        step();
        chk("seq_addr1", icache_addr, 1);
        chk("seq_bubble", valid_ppl, 0);
        step();
        chk("seq_addr2", icache_addr, 2);
        expect_out("seq0", 32'h00000013, 32'h0, 0);
        step();
        expect_out("seq1", 32'h00100093, 32'h4, 0);
        step();
        expect_out("seq2", 32'h00200113, 32'h8, 0);
        step();

        // RVC pair
        fill_nop();
        prog[0] = 32'h00010001;
        prog[1] = 32'h00000013;
        do_reset();
        wait_valid("rvc");
        expect_out("rvc0", 32'h1, 32'h0, 1);
        step();
        expect_out("rvc1", 32'h1, 32'h2, 1);
        step();
        expect_out("rvc2", 32'h13, 32'h4, 0);
        step();

        // 32-bit instruction straddling a word boundary
        fill_nop();
        prog[0] = 32'h00130001;
        prog[1] = 32'hABCD0000;
        do_reset();
        wait_valid("str");
        expect_out("str0", 32'h1, 32'h0, 1);
        step();
        expect_out("str1", 32'h00000013, 32'h2, 0);
        step();
        expect_out("str2", 32'h0000ABCD, 32'h6, 1);
        step();

        // decode backpressure
        fill_nop();
        do_reset();
        wait_valid("bp");
        chk("bp_pc0", pc_ppl, 0);
        step();
        step();
        chk("bp_pc8", pc_ppl, 8);
        stall = 1;
        repeat (10) step();
        chk("bp_full", queue_count, 4);
        chk("bp_ren_off", icache_ren, 0);
        chk("bp_hold_pc", pc_ppl, 8);
        chk("bp_hold_valid", valid_ppl, 1);
        stall = 0;
        step();
        expect_out("bp_release", NOP, 32'hC, 0);
        chk("bp_ren_back", icache_ren, 1);
        chk("bp_count3", queue_count, 3);
        step();
        expect_out("bp_next", NOP, 32'h10, 0);
        step();

        // redirect while a request is stalled
        fill_nop();
        do_reset();
        enter_drain();
        repeat (3) begin
            chk("drain_ren", icache_ren, 1);
            chk("drain_addr", icache_addr, 5);
            chk("drain_count", queue_count, 0);
            step();
        end
        icache_stall = 0;
        step();
        chk("restart_addr", icache_addr, 30'h40);
        chk("restart_ren", icache_ren, 1);
        wait_valid("restart");
        chk("restart_pc_ppl", pc_ppl, 32'h102);
        step();

        // asynchronous reset while draining
        fill_nop();
        do_reset();
        enter_drain();
        step();
        #3;
        rst = 1;
        #1;
        chk("arst_ren", icache_ren, 0);
        chk("arst_count", queue_count, 0);
        chk("arst_inst", inst_ppl, NOP);
        chk("arst_valid", valid_ppl, 0);
        @(negedge clk);
        @(negedge clk);
        icache_stall = 0;
        rst = 0;
        model_reset();
        #1;
        chk("arst_addr0", icache_addr, 0);
        wait_valid("arst");
        chk("arst_pc_ppl", pc_ppl, 0);
        step();

        // randomized traffic
        for (int i = 0; i < 256; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(0, 1) == 0) lo[1:0] = 2'b11;
            else if (lo[1:0] == 2'b11) lo[1:0] = 2'b01;
            if ($urandom_range(0, 1) == 0) hi[1:0] = 2'b11;
            else if (hi[1:0] == 2'b11) hi[1:0] = 2'b10;
            prog[i] = {hi, lo};
        end
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            icache_stall   = ($urandom_range(0, 99) < 30);
            stall          = ($urandom_range(0, 99) < 20);
            flush          = ($urandom_range(0, 99) < 10);
            redirect_valid = ($urandom_range(0, 99) < 5);
            redirect_pc    = 32'($urandom_range(0, 1023));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
